// File: rtl/dot_product_seq_if.sv
// Operand, mac-side and result handshake bundle for dot_product_seq.
// The slave modport is the sequencer's view; master is the surrounding system.
interface dot_product_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int VEC_LEN_W  = 8
);
    logic                  start;
    logic [VEC_LEN_W-1:0]  vec_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  mac_rst;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [OUT_WIDTH-1:0]  mac_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [OUT_WIDTH-1:0]  res_data;
    logic                  busy;

    modport slave (
        input  start, vec_len, in_valid, in_a, in_b, mac_out, res_ready,
        output in_ready, mac_rst, mac_a, mac_b, res_valid, res_data, busy
    );

    modport master (
        output start, vec_len, in_valid, in_a, in_b, mac_out, res_ready,
        input  in_ready, mac_rst, mac_a, mac_b, res_valid, res_data, busy
    );
endinterface

// File: rtl/dot_product_seq.sv
// Feeds vec_len operand pairs into an external mac, waits out its latency,
// then holds the accumulated dot product on a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for start; mac held cleared
// FEED  | accepting operand pairs into mac
// DRAIN | letting the last product reach mac_out (MAC_LAT+1 cycles)
// HOLD  | result valid until res_ready; mac held cleared
module dot_product_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int VEC_LEN_W  = 8,
    parameter int MAC_LAT    = 1
) (
    input  logic clk,
    input  logic rst,
    dot_product_seq_if.slave bus
);
    localparam int DRAIN_W = $clog2(MAC_LAT + 2);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;

    state_t                state;
    logic [VEC_LEN_W-1:0]  remaining;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic [DATA_WIDTH-1:0] mac_a_q;
    logic [DATA_WIDTH-1:0] mac_b_q;
    logic [OUT_WIDTH-1:0]  res_data_q;
    logic                  in_ready_q;
    logic                  res_valid_q;
    logic                  busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            remaining   <= '0;
            drain_cnt   <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_data_q  <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Any cycle without an accepted pair feeds zeros so mac adds nothing.
            mac_a_q <= '0;
            mac_b_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.vec_len != '0) begin
                            remaining  <= bus.vec_len;
                            in_ready_q <= 1'b1;
                            state      <= FEED;
                        end else begin
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                FEED: begin
                    if (bus.in_valid && in_ready_q) begin
                        mac_a_q   <= bus.in_a;
                        mac_b_q   <= bus.in_b;
                        remaining <= remaining - 1'b1;
                        if (remaining == VEC_LEN_W'(1)) begin
                            drain_cnt  <= DRAIN_W'(MAC_LAT);
                            in_ready_q <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        res_data_q  <= bus.mac_out;
                        res_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.mac_rst   = (state == IDLE) || (state == HOLD);
    assign bus.in_ready  = in_ready_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = busy_q;
endmodule
